// File: rtl/sprite_frame_engine.sv
// Sprite frame engine: each frame waits FRAME_TICKS, erases sprites at their old positions from
// the background, then draws them at new positions from sprite ROM. Optional macro: TRANSPARENCY_EN.
module sprite_frame_engine #(
    parameter int NUM_SPR     = 2,
    parameter int SPR_W       = 4,
    parameter int SPR_H       = 4,
    parameter int FRAME_TICKS = 833333
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   run,
    input  logic [NUM_SPR-1:0]     spr_en,
    input  logic [8*NUM_SPR-1:0]   spr_x,
    input  logic [7*NUM_SPR-1:0]   spr_y,
    output logic [14:0]            bg_addr,
    input  logic [8:0]             bg_q,
    output logic [14:0]            spr_addr,
    input  logic [8:0]             spr_q,
    output logic [7:0]             oX,
    output logic [6:0]             oY,
    output logic [8:0]             oColour,
    output logic                   oPlot,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int CW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam int XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int YW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, ERASE, DRAW, DONE} state_t;

    state_t               state;
    logic [TW-1:0]        tick;
    logic [CW-1:0]        ch;
    logic [XW-1:0]        px;
    logic [YW-1:0]        py;
    logic [7:0]           oldX [NUM_SPR];
    logic [6:0]           oldY [NUM_SPR];
    logic [NUM_SPR-1:0]   oldValid;
    logic [7:0]           newX [NUM_SPR];
    logic [6:0]           newY [NUM_SPR];
    logic [NUM_SPR-1:0]   newEn;
    logic                 plotReg;
    logic                 pixValid;
    logic                 pixErase;

    logic                 erasing;
    logic                 chActive;
    logic                 lastPix;
    logic                 chDone;
    logic                 lastCh;
    logic [7:0]           baseX;
    logic [6:0]           baseY;
    logic [8:0]           sumX;
    logic [8:0]           sumY;
    logic                 inBounds;

    // Addresses are driven combinationally from the scan counters; the memories register them,
    // so the pixel registers below line up with q one cycle later.
    always_comb begin
        erasing  = (state == ERASE);
        baseX    = erasing ? oldX[ch] : newX[ch];
        baseY    = erasing ? oldY[ch] : newY[ch];
        chActive = erasing ? oldValid[ch] : ((state == DRAW) && newEn[ch]);
        sumX     = {1'b0, baseX} + 9'(px);
        sumY     = {2'b0, baseY} + 9'(py);
        inBounds = (sumX < 9'd160) && (sumY < 9'd120);
        lastPix  = (px == XW'(SPR_W - 1)) && (py == YW'(SPR_H - 1));
        chDone   = !chActive || lastPix;
        lastCh   = (ch == CW'(NUM_SPR - 1));
        bg_addr  = '0;
        spr_addr = '0;
        if (chActive && erasing)
            bg_addr = 15'(sumY) * 15'd160 + 15'(sumX);
        if (chActive && !erasing)
            spr_addr = 15'(ch) * 15'(SPR_W * SPR_H) + 15'(py) * 15'(SPR_W) + 15'(px);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            tick       <= '0;
            ch         <= '0;
            px         <= '0;
            py         <= '0;
            oldValid   <= '0;
            newEn      <= '0;
            for (int unsigned i = 0; i < NUM_SPR; i++) begin
                oldX[i] <= '0;
                oldY[i] <= '0;
                newX[i] <= '0;
                newY[i] <= '0;
            end
            oX         <= '0;
            oY         <= '0;
            plotReg    <= 1'b0;
            pixValid   <= 1'b0;
            pixErase   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            plotReg    <= 1'b0;
            pixValid   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= WAIT;
                        tick  <= '0;
                    end
                end
                WAIT: begin
                    if (tick == TW'(FRAME_TICKS - 1)) begin
                        state <= ERASE;
                        tick  <= '0;
                        ch    <= '0;
                        px    <= '0;
                        py    <= '0;
                        newEn <= spr_en;
                        for (int unsigned i = 0; i < NUM_SPR; i++) begin
                            newX[i] <= spr_x[8*i +: 8];
                            newY[i] <= spr_y[7*i +: 7];
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                ERASE, DRAW: begin
                    if (chActive) begin
                        pixValid <= 1'b1;
                        pixErase <= erasing;
                        plotReg  <= inBounds;
                        oX       <= sumX[7:0];
                        oY       <= sumY[6:0];
                    end
                    if (chDone) begin
                        px <= '0;
                        py <= '0;
                        if (lastCh) begin
                            ch <= '0;
                            if (erasing) begin
                                state <= DRAW;
                            end else begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end
                        end else begin
                            ch <= ch + CW'(1);
                        end
                    end else if (px == XW'(SPR_W - 1)) begin
                        px <= '0;
                        py <= py + YW'(1);
                    end else begin
                        px <= px + XW'(1);
                    end
                end
                DONE: begin
                    oldValid <= newEn;
                    for (int unsigned i = 0; i < NUM_SPR; i++) begin
                        oldX[i] <= newX[i];
                        oldY[i] <= newY[i];
                    end
                    tick  <= '0;
                    state <= run ? WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == ERASE) || (state == DRAW) || (state == DONE);
    assign oColour = pixValid ? (pixErase ? bg_q : spr_q) : '0;

`ifdef TRANSPARENCY_EN
    // Colour 000 in sprite ROM is see-through; erase pixels always restore the background.
    assign oPlot = plotReg && !(!pixErase && (spr_q == 9'h000));
`else
    assign oPlot = plotReg;
`endif

endmodule

// File: tb/tb_sprite_frame_engine.sv
// Scoreboard bench for sprite_frame_engine: a frame-level model lists the pixels each frame must
// plot and its busy length; a negedge monitor consumes them as the DUT presents output.
module tb_sprite_frame_engine;

    localparam int NUM_SPR     = 2;
    localparam int SPR_W       = 4;
    localparam int SPR_H       = 4;
    localparam int FRAME_TICKS = 8;
    localparam int NPIX        = SPR_W * SPR_H;

`ifdef TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic [1:0]  spr_en = '0;
    logic [15:0] spr_x = '0;
    logic [13:0] spr_y = '0;
    logic [14:0] bg_addr;
    logic [8:0]  bg_q = '0;
    logic [14:0] spr_addr;
    logic [8:0]  spr_q = '0;
    logic [7:0]  oX;
    logic [6:0]  oY;
    logic [8:0]  oColour;
    logic        oPlot;
    logic        busy;
    logic        frame_done;

    always #5 clock = ~clock;

    sprite_frame_engine #(
        .NUM_SPR(NUM_SPR),
        .SPR_W(SPR_W),
        .SPR_H(SPR_H),
        .FRAME_TICKS(FRAME_TICKS)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .run(run),
        .spr_en(spr_en),
        .spr_x(spr_x),
        .spr_y(spr_y),
        .bg_addr(bg_addr),
        .bg_q(bg_q),
        .spr_addr(spr_addr),
        .spr_q(spr_q),
        .oX(oX),
        .oY(oY),
        .oColour(oColour),
        .oPlot(oPlot),
        .busy(busy),
        .frame_done(frame_done)
    );

    logic [8:0] bgMem  [32768];
    logic [8:0] romMem [32768];

    always @(posedge clock) begin
        bg_q  <= bgMem[bg_addr];
        spr_q <= romMem[spr_addr];
    end

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t expPix[$];
    int   expBusy[$];
    int   nCompared = 0;
    int   nMismatched = 0;

    int   oldXm [2];
    int   oldYm [2];
    bit   oldVm [2];

    function automatic void check(string name, int act, int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Frame model: erase lists every in-screen pixel of each previously drawn sprite in
    // background colour, draw lists the new sprites in ROM colour, channel by channel.
    task automatic planFrame(input int x0, input int y0, input int x1, input int y1,
                             input bit [1:0] en, output int eraseCost);
        int nx [2];
        int ny [2];
        int len;
        int xx;
        int yy;
        int col;
        nx[0] = x0; ny[0] = y0; nx[1] = x1; ny[1] = y1;
        spr_x  = {8'(x1), 8'(x0)};
        spr_y  = {7'(y1), 7'(y0)};
        spr_en = en;
        eraseCost = 0;
        for (int c = 0; c < 2; c++) begin
            eraseCost += oldVm[c] ? NPIX : 1;
            if (oldVm[c]) begin
                for (int r = 0; r < SPR_H; r++) begin
                    for (int k = 0; k < SPR_W; k++) begin
                        xx = oldXm[c] + k;
                        yy = oldYm[c] + r;
                        if (xx < 160 && yy < 120)
                            expPix.push_back('{x: xx, y: yy, c: int'(bgMem[yy * 160 + xx])});
                    end
                end
            end
        end
        len = eraseCost + 1;
        for (int c = 0; c < 2; c++) begin
            len += en[c] ? NPIX : 1;
            if (en[c]) begin
                for (int r = 0; r < SPR_H; r++) begin
                    for (int k = 0; k < SPR_W; k++) begin
                        xx  = nx[c] + k;
                        yy  = ny[c] + r;
                        col = int'(romMem[c * NPIX + r * SPR_W + k]);
                        if (xx < 160 && yy < 120 && !(TRANSP && col == 0))
                            expPix.push_back('{x: xx, y: yy, c: col});
                    end
                end
            end
        end
        expBusy.push_back(len);
        for (int c = 0; c < 2; c++) begin
            oldXm[c] = nx[c];
            oldYm[c] = ny[c];
            oldVm[c] = en[c];
        end
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            check("frame_done timeout", 0, 1);
    endtask

    // Monitor: pixel scoreboard, busy-length per frame, and WAIT length between frames.
    int busyCnt = 0;
    int gapCnt = 0;
    bit gapOn = 1'b0;

    always @(negedge clock) begin
        pix_t p;
        if (oPlot) begin
            if (expPix.size() == 0) begin
                check("unexpected plot", 1, 0);
            end else begin
                p = expPix.pop_front();
                check("pixel x", int'(oX), p.x);
                check("pixel y", int'(oY), p.y);
                check("pixel colour", int'(oColour), p.c);
            end
        end
        if (!resetn) begin
            busyCnt = 0;
            gapOn   = 1'b0;
        end else begin
            if (busy)
                busyCnt++;
            if (frame_done) begin
                if (expBusy.size() == 0)
                    check("unexpected frame_done", 1, 0);
                else
                    check("frame busy length", busyCnt, expBusy.pop_front());
                busyCnt = 0;
                gapCnt  = 0;
                gapOn   = run;
            end else if (gapOn) begin
                if (busy) begin
                    check("wait length", gapCnt, FRAME_TICKS);
                    gapOn = 1'b0;
                end else begin
                    gapCnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ec;
        int  x0, y0, x1, y1;
        bit [1:0] en;
        bit  ok;
        bit  idleBad;

        for (int a = 0; a < 32768; a++) begin
            bgMem[a]  = 9'h041;
            romMem[a] = 9'h155;
        end
        for (int a = 0; a < NPIX; a++) begin
            romMem[a]        = 9'h1FF;
            romMem[NPIX + a] = 9'($urandom_range(1, 511));
        end
        romMem[NPIX + 5] = 9'h000;
        for (int c = 0; c < 2; c++) begin
            oldXm[c] = 0; oldYm[c] = 0; oldVm[c] = 1'b0;
        end

        repeat (3) @(posedge clock);
        #1;
        check("reset oPlot", int'(oPlot), 0);
        check("reset busy", int'(busy), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset oX", int'(oX), 0);
        check("reset oY", int'(oY), 0);
        check("reset oColour", int'(oColour), 0);
        check("reset bg_addr", int'(bg_addr), 0);
        check("reset spr_addr", int'(spr_addr), 0);
        resetn = 1'b1;

        // First frame: no erase, ch0 solid 1FF at (10,20).
        planFrame(10, 20, 0, 0, 2'b01, ec);
        run = 1'b1;
        waitDone();
        // ch0 moves one pixel right over a flat 041 background.
        planFrame(11, 20, 0, 0, 2'b01, ec);
        waitDone();
        // ch1 clipped at the bottom-right corner; its ROM pixel 5 is colour 000.
        planFrame(11, 20, 158, 118, 2'b11, ec);
        waitDone();

        for (int a = 0; a < 19200; a++)
            bgMem[a] = 9'($urandom);
        for (int a = 0; a < 2 * NPIX; a++)
            romMem[a] = ($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom_range(1, 511));

        // run dropped during ERASE; inputs scrambled mid-frame must not matter.
        planFrame($urandom_range(0, 163), $urandom_range(0, 123),
                  $urandom_range(0, 163), $urandom_range(0, 123), 2'b11, ec);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("busy rise before run drop", int'(ok), 1);
        repeat (3) @(posedge clock);
        #1;
        run    = 1'b0;
        spr_x  = 16'($urandom);
        spr_y  = 14'($urandom);
        spr_en = 2'($urandom);
        waitDone();
        idleBad = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (busy || frame_done)
                idleBad = 1'b1;
        end
        check("stays idle after run drop", int'(idleBad), 0);

        for (int f = 0; f < 12; f++) begin
            x0 = $urandom_range(0, 163);
            y0 = $urandom_range(0, 123);
            x1 = $urandom_range(0, 163);
            y1 = $urandom_range(0, 123);
            en = 2'($urandom_range(0, 3));
            if (f == 5) begin
                x0 = $urandom_range(0, 150);
                y0 = $urandom_range(0, 110);
                en[0] = 1'b1;
            end
            planFrame(x0, y0, x1, y1, en, ec);
            if (!run)
                run = 1'b1;
            if (f == 5) begin
                // Reset lands on the fifth DRAW pixel of channel 0.
                ok = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clock);
                    if (busy) begin
                        ok = 1'b1;
                        break;
                    end
                end
                check("busy rise before reset", int'(ok), 1);
                repeat (ec + 4) @(posedge clock);
                #1;
                resetn = 1'b0;
                @(posedge clock);
                #1;
                check("oPlot after mid-draw reset", int'(oPlot), 0);
                check("busy after mid-draw reset", int'(busy), 0);
                expPix.delete();
                expBusy.delete();
                for (int c = 0; c < 2; c++)
                    oldVm[c] = 1'b0;
                @(posedge clock);
                #1;
                resetn = 1'b1;
            end else begin
                waitDone();
            end
        end

        run = 1'b0;
        repeat (5) @(negedge clock);
        check("pixels left unplotted", expPix.size(), 0);
        check("frames left unfinished", expBusy.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
